branch_unit_serial: RTL

- Parametrised digit-serial branch resolution unit for the serial RV32 core.
- Compares two operands streamed LSB-first, DIGIT bits per clock, and resolves all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) without borrowing the ALU's SUB/SLT result stream.
- Sits beside the ALU on the register-file digit bus; the fetch/PC logic consumes its registered taken/done result.

---
 rtl/branch_unit_serial_if.sv | 34 +++
 rtl/branch_unit_serial.sv | 127 ++++++++++++
 2 files changed

// File: rtl/branch_unit_serial_if.sv
// Digit bus between the register-file sequencer and the serial branch unit.
// One operation is requested by pulsing start; beat 0 digits ride with it.
interface branch_unit_serial_if #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 1
);
    localparam int NBEATS = XLEN / DIGIT;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    // Handshake: there is no ready. start is taken only in IDLE or FIN and
    // ignored while busy=1; once taken, one digit pair is consumed every cycle
    // until done pulses. flush aborts at any time and beats start.
    logic                start;
    logic [2:0]          func;
    logic [DIGIT-1:0]    op_a_digit;
    logic [DIGIT-1:0]    op_b_digit;
    logic                flush;
    logic                busy;
    logic [CW-1:0]       beat_idx;
    logic                done;
    logic                taken;
    logic                illegal;
    logic [1:0]          dbg_state;

    modport master (
        output start, func, op_a_digit, op_b_digit, flush,
        input  busy, beat_idx, done, taken, illegal, dbg_state
    );

    modport slave (
        input  start, func, op_a_digit, op_b_digit, flush,
        output busy, beat_idx, done, taken, illegal, dbg_state
    );
endinterface

// File: rtl/branch_unit_serial.sv
// Digit-serial RV32I branch resolver: streams rs1/rs2 LSB-first and keeps a
// running equal / less-than pair, signed only on the most significant digit.
module branch_unit_serial #(
    parameter int XLEN  = 32,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_unit_serial_if.slave  bus
);
    localparam int NBEATS = XLEN / DIGIT;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    state_t        state;
    logic [CW-1:0] beat_idx;
    logic          busy, done, taken, illegal;
    logic          eq, lt;
    logic [2:0]    func_q;

    logic          accept, is_last, eq_prev, lt_prev;
    logic          dig_eq, dig_lt, eq_n, lt_n, take_n, illegal_n;
    logic [2:0]    func_cur;

    always_comb begin
        accept   = bus.start && (state != RUN);
        func_cur = (state == RUN) ? func_q : bus.func;
        is_last  = (state == RUN) ? (beat_idx == LAST) : (NBEATS == 1);
        // A fresh operation always starts from "equal so far".
        eq_prev  = (state == RUN) ? eq : 1'b1;
        lt_prev  = (state == RUN) ? lt : 1'b0;
        dig_eq   = (bus.op_a_digit == bus.op_b_digit);
        if (is_last && !func_cur[1])
            dig_lt = $signed(bus.op_a_digit) < $signed(bus.op_b_digit);
        else
            dig_lt = bus.op_a_digit < bus.op_b_digit;
        eq_n      = eq_prev & dig_eq;
        lt_n      = dig_lt | (dig_eq & lt_prev);
        take_n    = 1'b0;
        illegal_n = 1'b0;
        case (func_cur)
            3'b000:         take_n = eq_n;
            3'b001:         take_n = ~eq_n;
            3'b100, 3'b110: take_n = lt_n;
            3'b101, 3'b111: take_n = ~lt_n;
            default:        illegal_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
            eq       <= 1'b1;
            lt       <= 1'b0;
            func_q   <= 3'b000;
        end else if (bus.flush) begin
            state    <= IDLE;
            beat_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
            eq       <= 1'b1;
            lt       <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (accept) begin
                        func_q <= bus.func;
                        eq     <= eq_n;
                        lt     <= lt_n;
                        if (NBEATS == 1) begin
                            state    <= FIN;
                            done     <= 1'b1;
                            taken    <= take_n;
                            illegal  <= illegal_n;
                            beat_idx <= '0;
                        end else begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            beat_idx <= CW'(1);
                            taken    <= 1'b0;
                            illegal  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    eq <= eq_n;
                    lt <= lt_n;
                    if (is_last) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        beat_idx <= '0;
                        taken    <= take_n;
                        illegal  <= illegal_n;
                    end else begin
                        beat_idx <= beat_idx + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    beat_idx <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.beat_idx  = beat_idx;
    assign bus.done      = done;
    assign bus.taken     = taken;
    assign bus.illegal   = illegal;
    assign bus.dbg_state = state;
endmodule
